// File: rtl/minimax_mem_arbiter.sv
// minimax_mem_arbiter: lets the core's fetch port and data port share one
// single-port synchronous RAM (1-cycle read latency). Grants at most one
// access per cycle, round-robin under contention. Writes to the simulation
// exit register are captured here and never reach the RAM.
module minimax_mem_arbiter #(
  parameter int          ADDR_BITS = 12,
  parameter logic [31:0] EXIT_ADDR = 32'hfffffffc
) (
  input  logic                 clk,
  input  logic                 reset,
  // instruction fetch port
  input  logic                 i_req,
  input  logic [ADDR_BITS-1:0] i_addr,
  output logic                 i_ready,
  output logic                 i_rvalid,
  output logic [15:0]          i_rdata,
  // data port
  input  logic                 d_req,
  input  logic [31:0]          d_addr,
  input  logic [3:0]           d_wmask,
  input  logic [31:0]          d_wdata,
  output logic                 d_ready,
  output logic                 d_rvalid,
  output logic [31:0]          d_rdata,
  // RAM port
  output logic                 mem_en,
  output logic [ADDR_BITS-3:0] mem_addr,
  output logic [3:0]           mem_wmask,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  // status
  output logic                 exit_valid,
  output logic [31:0]          exit_code,
  output logic [15:0]          stall_count
);

  // Which requester won the most recent accept; the other one wins the
  // next contended cycle.
  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  grant_t      r_last_grant;
  logic        r_i_rvalid;
  logic        r_d_rvalid;
  logic        r_i_hi;        // fetch address bit 1 of the read in flight
  logic        r_exit_valid;
  logic [31:0] r_exit_code;
  logic [15:0] r_stall_count;

  logic w_grant_i;
  logic w_grant_d;
  logic w_exit_wr;
  logic w_stall;
  logic w_unused_addr0;

  // Byte-lane select within a halfword is irrelevant for 16-bit fetches.
  assign w_unused_addr0 = i_addr[0];

  // Full-word store to the exit register; partial stores there are plain
  // aliased RAM writes.
  assign w_exit_wr = (d_addr == EXIT_ADDR) && (d_wmask == 4'hf);

  // Round-robin grant; nothing is granted while reset is held.
  always_comb begin
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    if (!reset) begin
      if (i_req && d_req) begin
        w_grant_i = (r_last_grant == GRANT_D);
        w_grant_d = (r_last_grant == GRANT_I);
      end else begin
        w_grant_i = i_req;
        w_grant_d = d_req;
      end
    end
  end

  assign i_ready = w_grant_i;
  assign d_ready = w_grant_d;

  // A requester that asserts req without being granted loses this cycle.
  assign w_stall = (i_req & ~w_grant_i) | (d_req & ~w_grant_d);

  // RAM port steering; wmask is forced to zero whenever the strobe is low.
  always_comb begin
    mem_en    = 1'b0;
    mem_addr  = i_addr[ADDR_BITS-1:2];
    mem_wmask = 4'h0;
    mem_wdata = d_wdata;
    if (w_grant_d) begin
      mem_addr = d_addr[ADDR_BITS-1:2];
      if (!w_exit_wr) begin
        mem_en    = 1'b1;
        mem_wmask = d_wmask;
      end
    end else if (w_grant_i) begin
      mem_en = 1'b1;
    end
  end

  // Arbitration history and read-return tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= GRANT_D;
      r_i_rvalid   <= 1'b0;
      r_d_rvalid   <= 1'b0;
      r_i_hi       <= 1'b0;
    end else begin
      if (w_grant_i) begin
        r_last_grant <= GRANT_I;
      end else if (w_grant_d) begin
        r_last_grant <= GRANT_D;
      end
      r_i_rvalid <= w_grant_i;
      // Only true reads return data; exit writes carry a full mask.
      r_d_rvalid <= w_grant_d && (d_wmask == 4'h0);
      if (w_grant_i) begin
        r_i_hi <= i_addr[1];
      end
    end
  end

  // Exit register: first full-word write wins and is held until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_exit_valid <= 1'b0;
      r_exit_code  <= 32'h0;
    end else if (w_grant_d && w_exit_wr && !r_exit_valid) begin
      r_exit_valid <= 1'b1;
      r_exit_code  <= d_wdata;
    end
  end

  // Saturating count of cycles in which some request was held off.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= 16'h0;
    end else if (w_stall && (r_stall_count != 16'hffff)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  // Read data comes straight from the RAM; reset arriving in the return
  // cycle squashes the valid pulse immediately.
  assign i_rvalid    = r_i_rvalid & ~reset;
  assign d_rvalid    = r_d_rvalid & ~reset;
  assign i_rdata     = r_i_hi ? mem_rdata[31:16] : mem_rdata[15:0];
  assign d_rdata     = mem_rdata;
  assign exit_valid  = r_exit_valid;
  assign exit_code   = r_exit_code;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_minimax_mem_arbiter.sv
// Bench for minimax_mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_minimax_mem_arbiter;

  localparam int          AB   = 12;
  localparam logic [31:0] EXIT = 32'hfffffffc;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req;
  logic [AB-1:0] i_addr;
  logic          i_ready, i_rvalid;
  logic [15:0]   i_rdata;
  logic          d_req;
  logic [31:0]   d_addr;
  logic [3:0]    d_wmask;
  logic [31:0]   d_wdata;
  logic          d_ready, d_rvalid;
  logic [31:0]   d_rdata;
  logic          mem_en;
  logic [AB-3:0] mem_addr;
  logic [3:0]    mem_wmask;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          exit_valid;
  logic [31:0]   exit_code;
  logic [15:0]   stall_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  minimax_mem_arbiter #(.ADDR_BITS(AB), .EXIT_ADDR(EXIT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wmask(d_wmask), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .exit_valid(exit_valid), .exit_code(exit_code), .stall_count(stall_count)
  );

  // Single-port RAM device seen by the DUT (read-before-write, 1-cycle read).
  logic [31:0] ram [0:1023];
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: memory image, who won last, exit state, stall count
  // and the read result owed on the next cycle.
  logic [31:0] model_mem [0:1023];
  logic        m_last_data = 1'b1;
  logic        m_exit_valid = 1'b0;
  logic [31:0] m_exit_code = 32'h0;
  int          m_stall = 0;
  logic        p_i = 1'b0, p_d = 1'b0;
  logic [15:0] p_i_data = 16'h0;
  logic [31:0] p_d_data = 32'h0;

  initial begin
    for (int k = 0; k < 1024; k++) begin
      ram[k]       = 32'h0;
      model_mem[k] = 32'h0;
    end
  end

  // Compare process: one pass per cycle, mid-cycle when inputs are stable.
  always @(negedge clk) begin
    logic        g_i, g_d, is_exit, e_en;
    logic [3:0]  e_wm;
    logic [9:0]  widx;
    logic [31:0] w;

    chk("i_rvalid", 32'(i_rvalid), 32'(p_i && !reset));
    if (p_i && !reset) chk("i_rdata", 32'(i_rdata), 32'(p_i_data));
    chk("d_rvalid", 32'(d_rvalid), 32'(p_d && !reset));
    if (p_d && !reset) chk("d_rdata", d_rdata, p_d_data);

    g_i = 1'b0; g_d = 1'b0;
    if (!reset) begin
      if (i_req && d_req) begin
        g_i = m_last_data;
        g_d = !m_last_data;
      end else begin
        g_i = i_req;
        g_d = d_req;
      end
    end
    is_exit = (d_addr == EXIT) && (d_wmask == 4'hf);
    e_en    = g_i || (g_d && !is_exit);
    e_wm    = (g_d && !is_exit) ? d_wmask : 4'h0;
    widx    = g_d ? d_addr[11:2] : i_addr[11:2];

    chk("i_ready", 32'(i_ready), 32'(g_i));
    chk("d_ready", 32'(d_ready), 32'(g_d));
    chk("mem_en", 32'(mem_en), 32'(e_en));
    chk("mem_wmask", 32'(mem_wmask), 32'(e_wm));
    if (e_en) chk("mem_addr", 32'(mem_addr), 32'(widx));
    if (e_wm != 4'h0) chk("mem_wdata", mem_wdata, d_wdata);
    chk("exit_valid", 32'(exit_valid), 32'(m_exit_valid));
    chk("exit_code", exit_code, m_exit_code);
    chk("stall_count", 32'(stall_count), 32'(m_stall));

    if (reset) begin
      m_last_data  = 1'b1;
      m_exit_valid = 1'b0;
      m_exit_code  = 32'h0;
      m_stall      = 0;
      p_i = 1'b0;
      p_d = 1'b0;
    end else begin
      if (((i_req && !g_i) || (d_req && !g_d)) && m_stall < 65535) m_stall++;
      w        = model_mem[widx];
      p_i      = g_i;
      p_i_data = i_addr[1] ? w[31:16] : w[15:0];
      p_d      = g_d && (d_wmask == 4'h0);
      p_d_data = w;
      if (g_i || g_d) m_last_data = g_d;
      if (g_d && is_exit && !m_exit_valid) begin
        m_exit_valid = 1'b1;
        m_exit_code  = d_wdata;
      end
      if (g_d && !is_exit)
        for (int b = 0; b < 4; b++)
          if (d_wmask[b]) model_mem[widx][8*b +: 8] = d_wdata[8*b +: 8];
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask
  task automatic at_neg();
    @(negedge clk); #1;
  endtask
  task automatic dset(input logic r, input logic [31:0] a, input logic [3:0] m, input logic [31:0] wd);
    d_req = r; d_addr = a; d_wmask = m; d_wdata = wd;
  endtask

  initial begin
    reset = 1'b1; i_req = 1'b1; i_addr = '0;
    dset(1'b1, 32'h20, 4'h0, 32'h0);

    // Reset held with both requests up.
    repeat (3) begin
      at_neg();
      chk("rst_i_ready", 32'(i_ready), 32'd0);
      chk("rst_d_ready", 32'(d_ready), 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_rvalid", 32'(i_rvalid | d_rvalid), 32'd0);
      chk("rst_exit_valid", 32'(exit_valid), 32'd0);
      cyc();
    end

    // Contention from reset: I, D, I, D.
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      at_neg();
      chk("cont_i_ready", 32'(i_ready), 32'(k % 2 == 0));
      chk("cont_d_ready", 32'(d_ready), 32'(k % 2 == 1));
      if (k == 0) chk("cont_stall0", 32'(stall_count), 32'd0);
      cyc();
    end
    i_req = 1'b0; d_req = 1'b0;
    at_neg();
    chk("cont_stall4", 32'(stall_count), 32'd4);
    chk("cont_d_rvalid", 32'(d_rvalid), 32'd1);
    cyc();

    // Fetch stream over word 0 = 0x12345678.
    dset(1'b1, 32'h0, 4'hf, 32'h12345678);
    cyc();
    d_req = 1'b0; i_req = 1'b1; i_addr = 12'h000;
    at_neg();
    chk("fs_ready0", 32'(i_ready), 32'd1);
    cyc();
    i_addr = 12'h002;
    at_neg();
    chk("fs_ready1", 32'(i_ready), 32'd1);
    chk("fs_rvalid0", 32'(i_rvalid), 32'd1);
    chk("fs_rdata0", 32'(i_rdata), 32'h5678);
    cyc();
    i_req = 1'b0;
    at_neg();
    chk("fs_rvalid1", 32'(i_rvalid), 32'd1);
    chk("fs_rdata1", 32'(i_rdata), 32'h1234);
    cyc();

    // Partial write then read back.
    dset(1'b1, 32'h10, 4'hf, 32'h11111111);
    cyc();
    dset(1'b1, 32'h10, 4'h3, 32'hAABBCCDD);
    at_neg();
    chk("pw_mem_addr", 32'(mem_addr), 32'd4);
    chk("pw_mem_wmask", 32'(mem_wmask), 32'd3);
    cyc();
    dset(1'b1, 32'h10, 4'h0, 32'h0);
    at_neg();
    chk("pw_no_rvalid", 32'(d_rvalid), 32'd0);
    cyc();
    d_req = 1'b0;
    at_neg();
    chk("pw_rvalid", 32'(d_rvalid), 32'd1);
    chk("pw_rdata", d_rdata, 32'h1111CCDD);
    cyc();

    // Exit writes: 0 then 5.
    dset(1'b1, EXIT, 4'hf, 32'd0);
    at_neg();
    chk("ex_mem_en0", 32'(mem_en), 32'd0);
    chk("ex_ready0", 32'(d_ready), 32'd1);
    cyc();
    dset(1'b1, EXIT, 4'hf, 32'd5);
    at_neg();
    chk("ex_mem_en1", 32'(mem_en), 32'd0);
    chk("ex_valid", 32'(exit_valid), 32'd1);
    cyc();
    d_req = 1'b0;
    at_neg();
    chk("ex_code", exit_code, 32'd0);
    cyc();

    // Reset right after an accepted read.
    dset(1'b1, 32'h10, 4'h0, 32'h0);
    at_neg();
    chk("rm_ready", 32'(d_ready), 32'd1);
    cyc();
    reset = 1'b1; d_req = 1'b0;
    at_neg();
    chk("rm_no_rvalid", 32'(d_rvalid), 32'd0);
    cyc();
    reset = 1'b0;
    at_neg();
    chk("rm_exit_valid", 32'(exit_valid), 32'd0);
    chk("rm_stall", 32'(stall_count), 32'd0);
    cyc();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      reset  = ($urandom_range(0, 299) == 0);
      i_req  = 1'($urandom_range(0, 1));
      i_addr = 12'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
      d_req  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        d_addr  = EXIT;
        d_wmask = ($urandom_range(0, 1) == 1) ? 4'hf : 4'h0;
      end else begin
        d_addr  = ($urandom & 32'hfffff000) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
        d_wmask = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
      end
      d_wdata = $urandom;
      cyc();
    end

    reset = 1'b0; i_req = 1'b0; d_req = 1'b0;
    repeat (3) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
